// File: rtl/photon_pkg.sv
// Shared definitions for the photon pulse path: emitter FSM states and the
// minimum period/width limits applied when a pulse is launched.
package photon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } emit_state_t;

  // Shortest legal period: one high cycle plus at least one low cycle.
  localparam int MIN_INTERVAL = 2;
  // Shortest legal high time.
  localparam int MIN_WIDTH    = 1;

endpackage

// File: rtl/photon_pulse_emitter.sv
// Programmable pulse-train source. Emits bursts of registered pulses whose
// period follows the lock-in phase flag at each launch, and keeps total,
// up-phase and down-phase tallies of the pulses it has emitted.
module photon_pulse_emitter
  import photon_pkg::*;
#(
  parameter int COUNTSIZE = 32,
  parameter int WIDTHSIZE = 8
) (
  input  logic                 c_clk,
  input  logic                 c_rst,
  input  logic                 c_start,
  input  logic                 c_stop,
  input  logic [COUNTSIZE-1:0] c_burst_len,
  input  logic [COUNTSIZE-1:0] c_up_interval,
  input  logic [COUNTSIZE-1:0] c_down_interval,
  input  logic [WIDTHSIZE-1:0] c_pulse_width,
  input  logic                 c_lockin_inc,
  output logic                 c_pulse_out,
  output logic                 c_busy,
  output logic                 c_done,
  output logic [COUNTSIZE-1:0] c_emitted_cnt,
  output logic [COUNTSIZE-1:0] c_emitted_up_cnt,
  output logic [COUNTSIZE-1:0] c_emitted_down_cnt
);

  // Period below the minimum is raised to the minimum.
  function automatic logic [COUNTSIZE-1:0] clamp_period(input logic [COUNTSIZE-1:0] p);
    if (p < COUNTSIZE'(MIN_INTERVAL)) return COUNTSIZE'(MIN_INTERVAL);
    return p;
  endfunction

  // Width is raised to the minimum, then capped so at least one low cycle remains.
  function automatic logic [COUNTSIZE-1:0] clamp_width(input logic [WIDTHSIZE-1:0] w,
                                                       input logic [COUNTSIZE-1:0] p);
    logic [COUNTSIZE-1:0] wx;
    wx = COUNTSIZE'(w);
    if (wx < COUNTSIZE'(MIN_WIDTH)) wx = COUNTSIZE'(MIN_WIDTH);
    if (wx >= p) wx = p - COUNTSIZE'(1);
    return wx;
  endfunction

  emit_state_t          state_q, state_d;
  logic                 pulse_q, pulse_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [COUNTSIZE-1:0] cnt_q, cnt_d;
  logic [COUNTSIZE-1:0] up_q, up_d;
  logic [COUNTSIZE-1:0] down_q, down_d;

  // Per-burst and per-pulse parameters; they only matter once a burst runs,
  // so they carry no reset.
  logic [COUNTSIZE-1:0] blen_q, blen_d;
  logic [WIDTHSIZE-1:0] width_q, width_d;
  logic [COUNTSIZE-1:0] period_q, period_d;
  logic [COUNTSIZE-1:0] effw_q, effw_d;
  logic [COUNTSIZE-1:0] timer_q, timer_d;

  logic                 launch;
  logic [WIDTHSIZE-1:0] w_sel;
  logic [COUNTSIZE-1:0] p_sel;

  // Next-state logic: stop has priority, then per-state sequencing, then launch.
  always_comb begin
    state_d  = state_q;
    pulse_d  = pulse_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    up_d     = up_q;
    down_d   = down_q;
    blen_d   = blen_q;
    width_d  = width_q;
    period_d = period_q;
    effw_d   = effw_q;
    timer_d  = timer_q;
    launch   = 1'b0;
    w_sel    = width_q;
    p_sel    = clamp_period(c_lockin_inc ? c_up_interval : c_down_interval);

    if (c_stop) begin
      state_d = ST_IDLE;
      pulse_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (c_start) begin
            blen_d  = c_burst_len;
            width_d = c_pulse_width;
            w_sel   = c_pulse_width;
            cnt_d   = '0;
            up_d    = '0;
            down_d  = '0;
            launch  = 1'b1;
          end
        end
        ST_HIGH: begin
          timer_d = timer_q + COUNTSIZE'(1);
          if (timer_q == effw_q) begin
            state_d = ST_LOW;
            pulse_d = 1'b0;
          end
        end
        ST_LOW: begin
          timer_d = timer_q + COUNTSIZE'(1);
          if (timer_q == period_q) begin
            if ((blen_q != '0) && (cnt_q == blen_q)) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              launch = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          pulse_d = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end

    if (launch) begin
      state_d  = ST_HIGH;
      pulse_d  = 1'b1;
      busy_d   = 1'b1;
      period_d = p_sel;
      effw_d   = clamp_width(w_sel, p_sel);
      timer_d  = COUNTSIZE'(1);
      cnt_d    = cnt_d + COUNTSIZE'(1);
      if (c_lockin_inc) up_d = up_d + COUNTSIZE'(1);
      else              down_d = down_d + COUNTSIZE'(1);
    end
  end

  // Control state and tallies, cleared by reset.
  always_ff @(posedge c_clk) begin
    if (c_rst) begin
      state_q <= ST_IDLE;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      up_q    <= '0;
      down_q  <= '0;
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      up_q    <= up_d;
      down_q  <= down_d;
    end
  end

  // Burst and pulse parameters plus the period timer.
  always_ff @(posedge c_clk) begin
    blen_q   <= blen_d;
    width_q  <= width_d;
    period_q <= period_d;
    effw_q   <= effw_d;
    timer_q  <= timer_d;
  end

  assign c_pulse_out        = pulse_q;
  assign c_busy             = busy_q;
  assign c_done             = done_q;
  assign c_emitted_cnt      = cnt_q;
  assign c_emitted_up_cnt   = up_q;
  assign c_emitted_down_cnt = down_q;

endmodule

// File: tb/tb_photon_pulse_emitter.sv
// Bench for photon_pulse_emitter: table-driven bursts plus hand-written
// sequences for phase switching, stop, start-while-busy and mid-burst reset.
module tb_photon_pulse_emitter;

  localparam int CS = 32;
  localparam int WS = 8;

  logic          c_clk = 1'b0;
  logic          c_rst;
  logic          c_start;
  logic          c_stop;
  logic [CS-1:0] c_burst_len;
  logic [CS-1:0] c_up_interval;
  logic [CS-1:0] c_down_interval;
  logic [WS-1:0] c_pulse_width;
  logic          c_lockin_inc;
  logic          c_pulse_out;
  logic          c_busy;
  logic          c_done;
  logic [CS-1:0] c_emitted_cnt;
  logic [CS-1:0] c_emitted_up_cnt;
  logic [CS-1:0] c_emitted_down_cnt;

  photon_pulse_emitter #(.COUNTSIZE(CS), .WIDTHSIZE(WS)) dut (
    .c_clk              (c_clk),
    .c_rst              (c_rst),
    .c_start            (c_start),
    .c_stop             (c_stop),
    .c_burst_len        (c_burst_len),
    .c_up_interval      (c_up_interval),
    .c_down_interval    (c_down_interval),
    .c_pulse_width      (c_pulse_width),
    .c_lockin_inc       (c_lockin_inc),
    .c_pulse_out        (c_pulse_out),
    .c_busy             (c_busy),
    .c_done             (c_done),
    .c_emitted_cnt      (c_emitted_cnt),
    .c_emitted_up_cnt   (c_emitted_up_cnt),
    .c_emitted_down_cnt (c_emitted_down_cnt)
  );

  always #5 c_clk = ~c_clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic p;
    logic b;
    logic d;
  } obs_t;

  obs_t exp_q[$];

  typedef struct {
    int up;
    int down;
    int w;
    int blen;
    int lock;
    int ep;       // expected effective period
    int ew;       // expected effective width
    int eup;      // expected up tally
    int edown;    // expected down tally
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Push expected per-cycle observations for t = 0 .. tlen-1 after the start edge.
  task automatic push_expect(input int rises[$], input int w, input int end_t,
                             input int done_t, input int tlen);
    obs_t o;
    for (int t = 0; t < tlen; t++) begin
      o.p = 1'b0;
      foreach (rises[j])
        if (t >= rises[j] && t < rises[j] + w && t < end_t) o.p = 1'b1;
      o.b = (t < end_t);
      o.d = (t == done_t);
      exp_q.push_back(o);
    end
  endtask

  task automatic pop_check(input string name);
    obs_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty, got pulse=%0b busy=%0b done=%0b expected an entry",
               name, c_pulse_out, c_busy, c_done);
    end else begin
      e = exp_q.pop_front();
      check({name, " pulse"}, 32'(c_pulse_out), 32'(e.p));
      check({name, " busy"},  32'(c_busy),      32'(e.b));
      check({name, " done"},  32'(c_done),      32'(e.d));
    end
  endtask

  task automatic check_tallies(input string name, input int n, input int u, input int d);
    check({name, " cnt"},  c_emitted_cnt,      32'(n));
    check({name, " up"},   c_emitted_up_cnt,   32'(u));
    check({name, " down"}, c_emitted_down_cnt, 32'(d));
  endtask

  // Drive a one-cycle start; returns at the falling edge right after the start edge (t=0).
  task automatic start_burst(input int up, input int down, input int w, input int blen,
                             input int lock);
    @(negedge c_clk);
    c_up_interval   = 32'(up);
    c_down_interval = 32'(down);
    c_pulse_width   = 8'(w);
    c_burst_len     = 32'(blen);
    c_lockin_inc    = lock[0];
    c_start         = 1'b1;
    @(negedge c_clk);
    c_start         = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int rises[$];
    int tlen;
    tlen = v.blen * v.ep + 3;
    for (int n = 0; n < v.blen; n++) rises.push_back(n * v.ep);
    exp_q.delete();
    push_expect(rises, v.ew, v.blen * v.ep, v.blen * v.ep, tlen);
    start_burst(v.up, v.down, v.w, v.blen, v.lock);
    for (int t = 0; t < tlen; t++) begin
      if (t > 0) @(negedge c_clk);
      pop_check($sformatf("%s t%0d", tag, t));
    end
    check_tallies(tag, v.blen, v.eup, v.edown);
  endtask

  vec_t vec[6];

  initial begin
    int rises[$];

    //        up  down  w  blen lock  ep  ew  eup edown
    vec[0] = '{10,  99,  3,  4,  1,   10,  3,  4,  0};  // basic burst
    vec[1] = '{99,   7,  2,  3,  0,    7,  2,  0,  3};  // down phase
    vec[2] = '{ 1,  99,  0,  3,  1,    2,  1,  3,  0};  // P=1,W=0 -> 2,1
    vec[3] = '{99,   5,  9,  2,  0,    5,  4,  0,  2};  // W>=P -> P-1
    vec[4] = '{ 0,  99,  5,  2,  1,    2,  1,  2,  0};  // P=0 -> 2, W -> 1
    vec[5] = '{ 3,  99,  1,  1,  1,    3,  1,  1,  0};  // single pulse

    c_rst = 1'b1; c_start = 1'b0; c_stop = 1'b0; c_burst_len = '0;
    c_up_interval = '0; c_down_interval = '0; c_pulse_width = '0; c_lockin_inc = 1'b0;
    repeat (3) @(negedge c_clk);
    check("reset pulse", 32'(c_pulse_out), 0);
    check("reset busy",  32'(c_busy), 0);
    check("reset done",  32'(c_done), 0);
    check_tallies("reset", 0, 0, 0);
    c_rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vec[i], $sformatf("vec%0d", i));

    // Continuous burst with phase changes; each period follows the flag at its launch.
    rises = '{0, 8, 20, 32};
    exp_q.delete();
    push_expect(rises, 4, 34, -1, 37);
    start_burst(8, 12, 4, 0, 1);
    for (int t = 0; t < 37; t++) begin
      if (t > 0) @(negedge c_clk);
      pop_check($sformatf("phase t%0d", t));
      if (t == 3)  c_lockin_inc = 1'b0;
      if (t == 22) c_lockin_inc = 1'b1;
      if (t == 33) c_stop = 1'b1;
      if (t == 34) c_stop = 1'b0;
    end
    check_tallies("phase", 4, 2, 2);

    // Stop together with start during pulse 2 of a 5-pulse burst.
    rises = '{0, 10};
    exp_q.delete();
    push_expect(rises, 3, 11, -1, 16);
    start_burst(10, 99, 3, 5, 1);
    for (int t = 0; t < 16; t++) begin
      if (t > 0) @(negedge c_clk);
      pop_check($sformatf("stop t%0d", t));
      if (t == 10) begin c_stop = 1'b1; c_start = 1'b1; end
      if (t == 11) begin c_stop = 1'b0; c_start = 1'b0; end
    end
    check_tallies("stop", 2, 2, 0);

    // Start while busy and on the completion edge is ignored; one cycle later it is accepted.
    rises = '{0, 10, 20, 30};
    exp_q.delete();
    push_expect(rises, 3, 40, 40, 41);
    exp_q.push_back('{1'b1, 1'b1, 1'b0});
    exp_q.push_back('{1'b0, 1'b0, 1'b0});
    start_burst(10, 99, 3, 4, 1);
    for (int t = 0; t < 43; t++) begin
      if (t > 0) @(negedge c_clk);
      pop_check($sformatf("busystart t%0d", t));
      if (t == 4)  c_start = 1'b1;
      if (t == 5)  c_start = 1'b0;
      if (t == 39) c_start = 1'b1;
      if (t == 41) begin c_start = 1'b0; c_stop = 1'b1; end
      if (t == 42) c_stop = 1'b0;
    end
    check_tallies("busystart", 1, 1, 0);

    // Reset during pulse 3, then a fresh basic burst.
    rises = '{0, 10, 20};
    exp_q.delete();
    push_expect(rises, 3, 21, -1, 21);
    start_burst(10, 99, 3, 4, 1);
    for (int t = 0; t < 21; t++) begin
      if (t > 0) @(negedge c_clk);
      pop_check($sformatf("rstmid t%0d", t));
      if (t == 20) c_rst = 1'b1;
    end
    @(negedge c_clk);
    check("rstmid pulse", 32'(c_pulse_out), 0);
    check("rstmid busy",  32'(c_busy), 0);
    check("rstmid done",  32'(c_done), 0);
    check_tallies("rstmid", 0, 0, 0);
    c_rst = 1'b0;
    run_vec(vec[0], "afterrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past limit, got no finish expected finish");
    $fatal(1);
  end

endmodule
